intersection_controller: RTL
============================

Name: intersection_controller

Overview:
Phase sequencer for a two-way (North-South / East-West) intersection. It drives two 3-lamp signal heads and a pedestrian WALK lamp. It holds each phase for a parameterised number of ticks, where one tick is a fixed number of clock cycles, and inserts an all-red clearance interval between directions. A latched pedestrian request adds an exclusive all-red WALK phase. The block is the top-level sequencer for the board's lamp outputs.

Parameters:
Clock_Frequency, 27_000_000, input clock in Hz; informational only, not used in RTL arithmetic.
TICK_CYCLES, 27_000_000, clock cycles per tick; 1 s at 27 MHz; must be ≥1.
GREEN_TICKS, 10, green duration in ticks; range 1..255.
YELLOW_TICKS, 3, yellow duration in ticks; range 1..255.
ALL_RED_TICKS, 1, all-red clearance duration in ticks; range 1..255.
WALK_TICKS, 5, pedestrian WALK duration in ticks; range 1..255.

Ports:
Clock  input  1  system clock; all logic on rising edge.
Reset_n  input  1  asynchronous, active-low reset.
Ped_Request  input  1  pedestrian button; synchronous to Clock, any width ≥1 cycle.
NS_R_LED, NS_Y_LED, NS_G_LED  output  1 each  North-South head.
EW_R_LED, EW_Y_LED, EW_G_LED  output  1 each  East-West head.
Walk_LED  output  1  pedestrian WALK lamp.
Ped_Ack  output  1  one-cycle pulse when a request is served.
Phase  output  3  current phase code, for debug and verification.

Behaviour:
- Phase register codes: 0 ALL_RED_A (clears into NS), 1 NS_GREEN, 2 NS_YELLOW, 3 ALL_RED_B (clears into EW), 4 EW_GREEN, 5 EW_YELLOW, 6 PED_WALK. Code 7 is illegal and goes to ALL_RED_A on the next edge.
- Reset (Reset_n low, asynchronous):
  - Phase=0, return_dir=NS, prescaler=0, tick timer=0, ped_pending=0, Ped_Ack=0.
  - Outputs: NS_R=EW_R=1, all Y/G=0, Walk=0.
  - Reset asserted mid-phase aborts immediately to this state.
- Lamp decode: combinational from the Phase register only; exactly one lamp lit per head.
  - NS_G only in phase 1; NS_Y only in 2; otherwise NS_R.
  - EW_G only in 4; EW_Y only in 5; otherwise EW_R.
  - Walk=1 only in phase 6. Both R lamps are on in phases 0, 3 and 6.
- Tick prescaler: counts 0..TICK_CYCLES-1. tick=1 for one cycle when prescaler==TICK_CYCLES-1.
- Tick timer: 8-bit, increments on each tick.
- On every phase change, prescaler and timer both load 0. Each phase therefore lasts exactly DUR×TICK_CYCLES cycles.
- Transition condition: tick && timer==DUR-1, where DUR is the current phase's duration.
- Sequence: 0→1→2→3→4→5→0.
- At the end of phase 0 or phase 3 with ped_pending=1:
  - Go to 6 instead of the next green. return_dir records the skipped green (NS from phase 0, EW from phase 3).
  - After phase 6, go to 1 if return_dir=NS, or 4 if return_dir=EW. No extra all-red.
- Ped_Request handling:
  - Sampled each cycle and sets sticky ped_pending in any phase except 6. Requests during phase 6 are ignored.
  - Multiple presses before service collapse to one WALK.
  - On the edge entering phase 6: ped_pending clears, and Ped_Ack=1 for exactly that one following cycle.
  - A request in the same cycle as the exit from an all-red phase is latched but not served in that transition; it is served at the next all-red exit.
- Green and yellow never go directly to the opposite direction's green.

Test Plan:
1. TICK_CYCLES=4, GREEN=5, YELLOW=2, ALL_RED=1, WALK=3; release reset, no requests -> Phase 0 for 4 cycles, 1 for 20, 2 for 8, 3 for 4, 4 for 20, 5 for 8, then back to 0; period 64 cycles; lamps match decode every cycle.
2. Same params; pulse Ped_Request 1 cycle during NS_GREEN -> after phase 3 (4 cycles), Phase=6 for 12 cycles with Walk=1 and both R=1; Ped_Ack high exactly 1 cycle at phase-6 entry; then Phase=4 (EW_GREEN).
3. Three pulses in one NS_GREEN plus a pulse during PED_WALK -> exactly one WALK served; next cycle runs with no WALK.
4. Request asserted in the final cycle of ALL_RED_A -> Phase goes 0→1, not 6; WALK occurs after the following ALL_RED_B.
5. Assert Reset_n low asynchronously mid-EW_GREEN (between edges) -> outputs go to all-red, Walk=0, Phase=0 without waiting for a clock edge; a pending request is cleared.
6. Force Phase=7 via the bench -> next edge Phase=0; TICK_CYCLES=1, all DUR=1 -> every phase lasts exactly 1 cycle.

Source files
------------

// File: rtl/intersection_controller.sv
// Two-way intersection phase sequencer with all-red clearance and an exclusive
// pedestrian WALK phase; phase timing is tick-based with a cycle prescaler.
module intersection_controller #(
  parameter int Clock_Frequency = 27_000_000,
  parameter int TICK_CYCLES     = 27_000_000,
  parameter int GREEN_TICKS     = 10,
  parameter int YELLOW_TICKS    = 3,
  parameter int ALL_RED_TICKS   = 1,
  parameter int WALK_TICKS      = 5
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Ped_Request,
  output logic       NS_R_LED,
  output logic       NS_Y_LED,
  output logic       NS_G_LED,
  output logic       EW_R_LED,
  output logic       EW_Y_LED,
  output logic       EW_G_LED,
  output logic       Walk_LED,
  output logic       Ped_Ack,
  output logic [2:0] Phase
);

  typedef enum logic [2:0] {
    ALL_RED_A = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALL_RED_B = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    PED_WALK  = 3'd6
  } phase_t;

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

  generate
    if (TICK_CYCLES < 1 || Clock_Frequency < 1) begin : g_param_check
      $error("intersection_controller: TICK_CYCLES and Clock_Frequency must be >= 1");
    end
  endgenerate

  logic [2:0]    phase_reg;
  phase_t        phase_next;
  logic [PW-1:0] prescale_reg;
  logic [7:0]    timer_reg;
  logic          ped_pending_reg;
  logic          return_ew_reg;
  logic          ped_ack_reg;

  logic       tick;
  logic [7:0] dur;
  logic       phase_done;
  logic       phase_change;
  logic       enter_walk;

  assign tick = (prescale_reg == TICK_LAST);

  always_comb begin
    dur = 8'(ALL_RED_TICKS);
    case (phase_reg)
      NS_GREEN, EW_GREEN:   dur = 8'(GREEN_TICKS);
      NS_YELLOW, EW_YELLOW: dur = 8'(YELLOW_TICKS);
      PED_WALK:             dur = 8'(WALK_TICKS);
      default:              dur = 8'(ALL_RED_TICKS);
    endcase
  end

  assign phase_done = tick && (timer_reg == dur - 8'd1);

  // All-red exits divert to WALK when a request is already latched.
  always_comb begin
    phase_next = ALL_RED_A;
    case (phase_reg)
      ALL_RED_A: phase_next = !phase_done ? ALL_RED_A :
                              (ped_pending_reg ? PED_WALK : NS_GREEN);
      NS_GREEN:  phase_next = phase_done ? NS_YELLOW : NS_GREEN;
      NS_YELLOW: phase_next = phase_done ? ALL_RED_B : NS_YELLOW;
      ALL_RED_B: phase_next = !phase_done ? ALL_RED_B :
                              (ped_pending_reg ? PED_WALK : EW_GREEN);
      EW_GREEN:  phase_next = phase_done ? EW_YELLOW : EW_GREEN;
      EW_YELLOW: phase_next = phase_done ? ALL_RED_A : EW_YELLOW;
      PED_WALK:  phase_next = !phase_done ? PED_WALK :
                              (return_ew_reg ? EW_GREEN : NS_GREEN);
      default:   phase_next = ALL_RED_A;
    endcase
  end

  assign phase_change = (phase_next != phase_reg);
  assign enter_walk   = phase_change && (phase_next == PED_WALK);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      phase_reg       <= ALL_RED_A;
      prescale_reg    <= '0;
      timer_reg       <= '0;
      ped_pending_reg <= 1'b0;
      return_ew_reg   <= 1'b0;
      ped_ack_reg     <= 1'b0;
    end else begin
      phase_reg   <= phase_next;
      ped_ack_reg <= enter_walk;
      if (phase_change) begin
        prescale_reg <= '0;
        timer_reg    <= '0;
      end else if (tick) begin
        prescale_reg <= '0;
        timer_reg    <= timer_reg + 8'd1;
      end else begin
        prescale_reg <= prescale_reg + PW'(1);
      end
      // Requests during WALK are dropped; the served request clears on entry.
      if (enter_walk) begin
        ped_pending_reg <= 1'b0;
        return_ew_reg   <= (phase_reg == ALL_RED_B);
      end else if (Ped_Request && phase_reg != PED_WALK) begin
        ped_pending_reg <= 1'b1;
      end
    end
  end

  assign NS_G_LED = (phase_reg == NS_GREEN);
  assign NS_Y_LED = (phase_reg == NS_YELLOW);
  assign NS_R_LED = !(NS_G_LED || NS_Y_LED);
  assign EW_G_LED = (phase_reg == EW_GREEN);
  assign EW_Y_LED = (phase_reg == EW_YELLOW);
  assign EW_R_LED = !(EW_G_LED || EW_Y_LED);
  assign Walk_LED = (phase_reg == PED_WALK);
  assign Ped_Ack  = ped_ack_reg;
  assign Phase    = phase_reg;

endmodule
